countdown_timer: RTL and testbench

Down-counting timer for the seven-segment stopwatch board: the other direction of the up-counting stopwatch. It takes debounced single-cycle button pulses to load, start/pause and clear, and counts down at 100 Hz from a loaded value to zero. On reaching zero it raises a done pulse and a latched alarm. `o_count` feeds the existing FND controller directly as a 14-bit binary value.

---
 rtl/countdown_pkg.sv | 18 +
 rtl/countdown_tick_gen.sv | 33 +++
 rtl/countdown_timer.sv | 132 +++++++++++++
 tb/tb_countdown_timer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer.
package countdown_pkg;

    localparam int unsigned CNT_W = 14;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    // Clamp a requested preset to the largest loadable value.
    function automatic logic [CNT_W-1:0] sat_load(input logic [CNT_W-1:0] value,
                                                  input logic [CNT_W-1:0] max_val);
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/countdown_tick_gen.sv
// Prescaler that emits one tick every CLK_HZ/TICK_HZ cycles while enabled.
// Held at zero while disabled, so a pause discards the partial period.
module countdown_tick_gen #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic o_tick
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] r_presc;

    // Count 0..DIV-1 while enabled, otherwise hold at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (!en) begin
            r_presc <= '0;
        end else if (r_presc == PW'(DIV - 1)) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign o_tick = en && (r_presc == PW'(DIV - 1));

endmodule

// File: rtl/countdown_timer.sv
// Down-counting 100 Hz timer with load, start/pause, clear and latched alarm.
// Optional: define COUNTDOWN_AUTO_RELOAD_EN to restart from the last loaded
// value on the final tick instead of entering ALARM.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned MAX_COUNT = 9999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run_stop,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    output logic [CNT_W-1:0] o_count,
    output logic             o_running,
    output logic             o_done,
    output logic             o_alarm
);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_reload;
    logic             r_running;
    logic             r_done;
    logic             r_alarm;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_reload_nxt;
    logic             w_done_nxt;
    logic             w_tick;
    logic             w_run_en;
    logic [CNT_W-1:0] w_load_sat;

    assign w_run_en   = (r_state == ST_RUN);
    assign w_load_sat = sat_load(i_load_value, CNT_W'(MAX_COUNT));

    countdown_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .en     (w_run_en),
        .o_tick (w_tick)
    );

    // Next-state, count and done decode; clear > run_stop > load.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_STOP: begin
                if (i_clear) begin
                    w_count_nxt = '0;
                end else if (i_run_stop) begin
                    if (r_count != '0) begin
                        w_state_nxt = ST_RUN;
                    end
                end else if (i_load) begin
                    w_count_nxt  = w_load_sat;
                    w_reload_nxt = w_load_sat;
                end
            end
            ST_RUN: begin
                if (i_clear) begin
                    w_state_nxt = ST_STOP;
                    w_count_nxt = '0;
                end else if (i_run_stop) begin
                    w_state_nxt = ST_STOP;
                end else if (w_tick) begin
                    if (r_count == CNT_W'(1)) begin
                        w_done_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (r_reload != '0) begin
                            w_count_nxt = r_reload;
                        end else begin
                            w_count_nxt = '0;
                            w_state_nxt = ST_ALARM;
                        end
`else
                        w_count_nxt = '0;
                        w_state_nxt = ST_ALARM;
`endif
                    end else if (r_count != '0) begin
                        w_count_nxt = r_count - CNT_W'(1);
                    end
                end
            end
            ST_ALARM: begin
                if (i_clear || i_run_stop) begin
                    w_state_nxt = ST_STOP;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_STOP;
                w_count_nxt = '0;
            end
        endcase
    end

    // State, count, reload value and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_STOP;
            r_count   <= '0;
            r_reload  <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_reload  <= w_reload_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_done    <= w_done_nxt;
            r_alarm   <= (w_state_nxt == ST_ALARM);
        end
    end

    assign o_count   = r_count;
    assign o_running = r_running;
    assign o_done    = r_done;
    assign o_alarm   = r_alarm;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (CLK_HZ=1000, TICK_HZ=100, DIV=10).
// Honours COUNTDOWN_AUTO_RELOAD_EN in its reference model.
module tb_countdown_timer;

    localparam int unsigned CLK_HZ    = 1000;
    localparam int unsigned TICK_HZ   = 100;
    localparam int          DIV       = CLK_HZ / TICK_HZ;
    localparam int          MAX_COUNT = 9999;

    logic        clk;
    logic        reset;
    logic        i_run_stop;
    logic        i_clear;
    logic        i_load;
    logic [13:0] i_load_value;
    logic [13:0] o_count;
    logic        o_running;
    logic        o_done;
    logic        o_alarm;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: remaining count, run/alarm flags, cycles into current period.
    int m_count, m_reload, m_elapsed;
    bit m_running, m_alarm, m_done;

    countdown_timer #(
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .MAX_COUNT (MAX_COUNT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_run_stop   (i_run_stop),
        .i_clear      (i_clear),
        .i_load       (i_load),
        .i_load_value (i_load_value),
        .o_count      (o_count),
        .o_running    (o_running),
        .o_done       (o_done),
        .o_alarm      (o_alarm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_count   = 0;
        m_reload  = 0;
        m_elapsed = 0;
        m_running = 0;
        m_alarm   = 0;
        m_done    = 0;
    endtask

    // One clock edge of behaviour, from the timer's rules.
    task automatic model_edge(input bit c, input bit r, input bit l, input int v);
        bit tick;
        m_done = 0;
        if (m_running) begin
            tick = (m_elapsed == DIV - 1);
            m_elapsed = tick ? 0 : m_elapsed + 1;
            if (c) begin
                m_running = 0;
                m_count   = 0;
            end else if (r) begin
                m_running = 0;
            end else if (tick) begin
                if (m_count == 1) begin
                    m_done = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (m_reload != 0) begin
                        m_count = m_reload;
                    end else begin
                        m_count   = 0;
                        m_running = 0;
                        m_alarm   = 1;
                    end
`else
                    m_count   = 0;
                    m_running = 0;
                    m_alarm   = 1;
`endif
                end else begin
                    m_count = m_count - 1;
                end
            end
        end else if (m_alarm) begin
            if (c || r) begin
                m_alarm = 0;
                m_count = 0;
            end
        end else begin
            if (c) begin
                m_count = 0;
            end else if (r) begin
                if (m_count != 0) begin
                    m_running = 1;
                    m_elapsed = 0;
                end
            end else if (l) begin
                m_count  = (v > MAX_COUNT) ? MAX_COUNT : v;
                m_reload = m_count;
            end
        end
    endtask

    task automatic check_all();
        check_eq("count",   32'(o_count),   32'(m_count));
        check_eq("running", 32'(o_running), 32'(m_running));
        check_eq("alarm",   32'(o_alarm),   32'(m_alarm));
        check_eq("done",    32'(o_done),    32'(m_done));
    endtask

    // Present one cycle of pulses, clock it, then compare against the model.
    task automatic step(input bit c, input bit r, input bit l, input int v);
        logic [31:0] lv;
        lv           = 32'(v);
        i_clear      = c;
        i_run_stop   = r;
        i_load       = l;
        i_load_value = lv[13:0];
        @(posedge clk);
        cyc++;
        model_edge(c, r, l, v);
        #1;
        check_all();
        i_clear    = 1'b0;
        i_run_stop = 1'b0;
        i_load     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0);
    endtask

    initial begin
        bit found;
        reset        = 1'b1;
        i_run_stop   = 1'b0;
        i_clear      = 1'b0;
        i_load       = 1'b0;
        i_load_value = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Load 3 and run to zero; alarm holds until run_stop.
        step(0, 0, 1, 3);
        step(0, 1, 0, 0);
        check_eq("run_entry", 32'(o_running), 32'd1);
        idle(35);
        step(0, 1, 0, 0);
        idle(2);

        // Saturating load, then run_stop at zero is ignored.
        step(0, 0, 1, 12000);
        check_eq("sat_load", 32'(o_count), 32'd9999);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        check_eq("run_at_zero", 32'(o_running), 32'd0);

        // Pause mid-period discards the partial period.
        step(0, 0, 1, 5);
        step(0, 1, 0, 0);
        idle(15);
        step(0, 1, 0, 0);
        check_eq("paused_count", 32'(o_count), 32'd4);
        idle(3);
        step(0, 1, 0, 0);
        idle(9);
        check_eq("resume_hold", 32'(o_count), 32'd4);
        idle(1);
        check_eq("resume_dec", 32'(o_count), 32'd3);
        step(0, 1, 0, 0);

        // Final tick coincident with run_stop: held at 1, no done.
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        step(0, 1, 0, 0);
        idle(9);
        step(0, 1, 0, 0);
        check_eq("coincident_count", 32'(o_count), 32'd1);
        step(1, 1, 1, 50);
        check_eq("clear_prio", 32'(o_count), 32'd0);

        // Asynchronous reset while running at count 7.
        step(0, 0, 1, 10);
        step(0, 1, 0, 0);
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (m_count == 7) found = 1;
            else step(0, 0, 0, 0);
        end
        check_eq("reach_seven", 32'(found), 32'd1);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Load 2 and run long enough for several final ticks.
        step(0, 0, 1, 2);
        step(0, 1, 0, 0);
        idle(45);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);

        // Randomised pulses against the model.
        for (int k = 0; k < 3000; k++) begin
            bit c, r, l;
            int v;
            c = ($urandom_range(0, 59) == 0);
            r = ($urandom_range(0, 14) == 0);
            l = ($urandom_range(0, 9) == 0);
            v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 16383))
                                            : int'($urandom_range(0, 6));
            step(c, r, l, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
